// File: rtl/pulse_pattern_generator.sv
// pulse_pattern_generator: replays one four-coordinate event as four 8:1 serializer word streams inside a fixed frame.
// Statistics counters are built only when PULSE_PATTERN_STATS_EN is defined.
module pulse_pattern_generator #(
    parameter int FRAME_CYCLES = 100,
    parameter int PULSE_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        valid_i,
    input  logic [9:0]  x1_coord_i,
    input  logic [9:0]  x2_coord_i,
    input  logic [9:0]  y1_coord_i,
    input  logic [9:0]  y2_coord_i,
    output logic [7:0]  x1_word_o,
    output logic [7:0]  x2_word_o,
    output logic [7:0]  y1_word_o,
    output logic [7:0]  y2_word_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic [15:0] event_count_o,
    output logic [15:0] drop_count_o
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [6:0] LAST = 7'(FRAME_CYCLES - 1);
    state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [9:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [7:0] x1_word_q, x1_word_d, x2_word_q, x2_word_d;
    logic [7:0] y1_word_q, y1_word_d, y2_word_q, y2_word_d;
    logic overrun_q, overrun_d;
    logic run, last, accept, drop;

    // Sub-slot t never exceeds 8*FRAME_CYCLES-1, so pulses past the frame end are truncated naturally.
    function automatic logic [7:0] gen_word(input logic [6:0] cnt, input logic [9:0] coord);
        logic [10:0] t, lo, hi;
        gen_word = '0;
        lo = {1'b0, coord};
        hi = lo + 11'(PULSE_WIDTH);
        for (int k = 0; k < 8; k++) begin
            t = {1'b0, cnt, 3'(k)};
            gen_word[k] = (t >= lo) && (t < hi);
        end
    endfunction

    always_comb begin
        run       = state_q == RUN;
        last      = run && cnt_q == LAST;
        accept    = load_i && valid_i && (!run || last);
        drop      = load_i && run && !last;
        state_d   = state_q;
        cnt_d     = cnt_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            x1_d    = x1_coord_i;
            x2_d    = x2_coord_i;
            y1_d    = y1_coord_i;
            y2_d    = y2_coord_i;
        end else if (last) begin
            state_d = IDLE;
        end else if (run) begin
            cnt_d = cnt_q + 7'd1;
        end
        overrun_d = drop;
        x1_word_d = run ? gen_word(cnt_q, x1_q) : '0;
        x2_word_d = run ? gen_word(cnt_q, x2_q) : '0;
        y1_word_d = run ? gen_word(cnt_q, y1_q) : '0;
        y2_word_d = run ? gen_word(cnt_q, y2_q) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            x1_word_q <= '0;
            x2_word_q <= '0;
            y1_word_q <= '0;
            y2_word_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            x1_word_q <= x1_word_d;
            x2_word_q <= x2_word_d;
            y1_word_q <= y1_word_d;
            y2_word_q <= y2_word_d;
            overrun_q <= overrun_d;
        end
    end

    assign x1_word_o = x1_word_q;
    assign x2_word_o = x2_word_q;
    assign y1_word_o = y1_word_q;
    assign y2_word_o = y2_word_q;
    assign busy_o    = run;
    assign done_o    = last;
    assign overrun_o = overrun_q;

`ifdef PULSE_PATTERN_STATS_EN
    logic [15:0] event_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (accept && event_cnt_q != 16'hFFFF) event_cnt_q <= event_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign event_count_o = event_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`else
    assign event_count_o = '0;
    assign drop_count_o  = '0;
`endif
endmodule

// File: tb/tb_pulse_pattern_generator.sv
// tb_pulse_pattern_generator: directed bench for pulse_pattern_generator with default parameters.
module tb_pulse_pattern_generator;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load_i = 1'b0;
    logic valid_i = 1'b0;
    logic [9:0] x1_coord_i = '0, x2_coord_i = '0, y1_coord_i = '0, y2_coord_i = '0;
    logic [7:0] x1_word_o, x2_word_o, y1_word_o, y2_word_o;
    logic busy_o, done_o, overrun_o;
    logic [15:0] event_count_o, drop_count_o;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_pattern_generator dut (
        .clk(clk), .reset(reset), .load_i(load_i), .valid_i(valid_i),
        .x1_coord_i(x1_coord_i), .x2_coord_i(x2_coord_i),
        .y1_coord_i(y1_coord_i), .y2_coord_i(y2_coord_i),
        .x1_word_o(x1_word_o), .x2_word_o(x2_word_o),
        .y1_word_o(y1_word_o), .y2_word_o(y2_word_o),
        .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
        .event_count_o(event_count_o), .drop_count_o(drop_count_o)
    );

    task automatic chk(input string tag, input int n, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
        load_i = 1'b1;
        valid_i = v;
        x1_coord_i = a;
        x2_coord_i = b;
        y1_coord_i = c;
        y2_coord_i = d;
    endtask

    task automatic check_all_zero(input int n);
        chk("x1_zero", n, 16'(x1_word_o), 16'h0);
        chk("x2_zero", n, 16'(x2_word_o), 16'h0);
        chk("y1_zero", n, 16'(y1_word_o), 16'h0);
        chk("y2_zero", n, 16'(y2_word_o), 16'h0);
        chk("busy_zero", n, 16'(busy_o), 16'h0);
        chk("done_zero", n, 16'(done_o), 16'h0);
        chk("overrun_zero", n, 16'(overrun_o), 16'h0);
    endtask

    initial begin
        logic [15:0] ev_exp, dr_exp;
        // reset state
        tick();
        tick();
        check_all_zero(0);
        chk("event_rst", 0, event_count_o, 16'h0);
        chk("drop_rst", 0, drop_count_o, 16'h0);
        reset = 1'b1;
        tick();

        // frame 1, a dropped load mid-frame, then back-to-back frame 2
        load(1'b1, 10'd32, 10'd37, 10'd797, 10'd0);
        for (int n = 1; n <= 205; n++) begin
            tick();
            load_i = 1'b0;
            chk("x1_word", n, 16'(x1_word_o), n == 6 ? 16'hFF : n == 102 ? 16'hF8 : n == 103 ? 16'h07 : 16'h0);
            chk("x2_word", n, 16'(x2_word_o), n == 6 ? 16'hE0 : n == 7 ? 16'h1F : n == 104 ? 16'hFF : 16'h0);
            chk("y1_word", n, 16'(y1_word_o), n == 101 ? 16'hE0 : 16'h0);
            chk("y2_word", n, 16'(y2_word_o), n == 2 ? 16'hFF : 16'h0);
            chk("busy", n, 16'(busy_o), (n >= 1 && n <= 200) ? 16'h1 : 16'h0);
            chk("done", n, 16'(done_o), (n == 100 || n == 200) ? 16'h1 : 16'h0);
            chk("overrun", n, 16'(overrun_o), n == 52 ? 16'h1 : 16'h0);
            if (n == 51) load(1'b1, 10'd500, 10'd500, 10'd500, 10'd500);
            if (n == 100) load(1'b1, 10'd3, 10'd16, 10'd1000, 10'd1020);
        end
`ifdef PULSE_PATTERN_STATS_EN
        ev_exp = 16'd2;
        dr_exp = 16'd1;
`else
        ev_exp = 16'd0;
        dr_exp = 16'd0;
`endif
        chk("event_after_frames", 205, event_count_o, ev_exp);
        chk("drop_after_frames", 205, drop_count_o, dr_exp);

        // load with valid_i low is ignored
        load(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        for (int n = 1; n <= 10; n++) begin
            tick();
            load_i = 1'b0;
            check_all_zero(n);
        end
        chk("event_invalid", 10, event_count_o, ev_exp);

        // asynchronous reset mid-frame, then a fresh event
        load(1'b1, 10'd80, 10'd0, 10'd0, 10'd0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            load_i = 1'b0;
        end
        chk("x1_before_reset", 12, 16'(x1_word_o), 16'hFF);
        chk("busy_before_reset", 12, 16'(busy_o), 16'h1);
        reset = 1'b0;
        #1;
        check_all_zero(12);
        chk("event_async_rst", 12, event_count_o, 16'h0);
        chk("drop_async_rst", 12, drop_count_o, 16'h0);
        tick();
        reset = 1'b1;
        tick();
        load(1'b1, 10'd1000, 10'd1000, 10'd1000, 10'd40);
        for (int n = 1; n <= 10; n++) begin
            tick();
            load_i = 1'b0;
            chk("y2_after_reset", n, 16'(y2_word_o), n == 7 ? 16'hFF : 16'h0);
            chk("x1_after_reset", n, 16'(x1_word_o), 16'h0);
        end
`ifdef PULSE_PATTERN_STATS_EN
        ev_exp = 16'd1;
`else
        ev_exp = 16'd0;
`endif
        chk("event_after_reset", 10, event_count_o, ev_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_pattern_generator.md
# pulse_pattern_generator

- Consumes one event (valid flag plus four 10-bit fine-time coordinates x1, x2, y1, y2) from the event generator.
- Replays the event as four independent pulse trains, one 8-bit serializer word per channel per clock, inside a fixed frame of FRAME_CYCLES cycles.
- Sits between the event generator and the four 8:1 output serializers (word bit 0 is shifted out first).
- Coordinate LSB is 1/8 clock: coord[9:3] selects the frame cycle and coord[2:0] the sub-slot.

## Interface
- FRAME_CYCLES, 100: frame length in clock cycles; legal range 2..128.
- PULSE_WIDTH, 8: pulse length in sub-slots (1/8 clk); legal range 1..64.
- clk  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-low reset.
- load_i  input  1  one-cycle strobe; coordinates and valid_i are sampled on it.
- valid_i  input  1  event qualifier, sampled with load_i.
- x1_coord_i, x2_coord_i, y1_coord_i, y2_coord_i  input  10 each  unsigned fine-time pulse starts.
- x1_word_o, x2_word_o, y1_word_o, y2_word_o  output  8 each  serializer words; bit k is sub-slot k.
- busy_o  output  1  high while a frame is running.
- done_o  output  1  one-cycle pulse in the last frame cycle.
- overrun_o  output  1  one-cycle pulse when load_i is dropped.
- event_count_o, drop_count_o  output  16 each  statistics counters (see Configuration).

## Operation
- FSM states: IDLE and RUN. Frame counter cnt is 7 bits.
- IDLE:
  - load_i & valid_i: latch the four coordinates, cnt <= 0, go to RUN.
  - load_i & !valid_i: stay in IDLE; no outputs change.
- RUN:
  - cnt increments by 1 each cycle.
  - When cnt == FRAME_CYCLES-1: done_o = 1, then go to IDLE.
  - If load_i & valid_i in that same cycle: accept the new event back-to-back (latch, cnt <= 0, stay in RUN).
- load_i while in RUN with cnt != FRAME_CYCLES-1: the event is dropped, coordinates are unchanged, and overrun_o pulses (regardless of valid_i).
- Word generation, per channel and sub-slot k: t = 8*cnt + k (11 bits); bit k = (t >= coord) && (t < coord + PULSE_WIDTH).
  - All arithmetic is 11-bit unsigned, so no wrap is possible.
  - A pulse running past sub-slot 8*FRAME_CYCLES-1 is truncated and does not carry into the next frame.
- Words are registered. They are 8'h00 in IDLE and in every cycle where no bit is set.
- busy_o = (state == RUN).

## Timing
- Reset values: all words 8'h00, busy_o 0, done_o 0, overrun_o 0, counters 0, state IDLE.
- Reset asserts asynchronously and aborts a frame immediately; release is synchronous to clk.
- Let load_i be accepted at cycle L:
  - busy_o is high from L+1 to L+FRAME_CYCLES.
  - The word for frame cycle c appears at L+2+c.
  - done_o is high at L+FRAME_CYCLES.
  - Last word appears at L+FRAME_CYCLES+1.
- Back-to-back acceptance in the final cycle gives contiguous frames with no gap.
- overrun_o is high in the cycle after the dropped load_i.
- Coordinates must be stable only in the load_i cycle.

## Configuration
- PULSE_PATTERN_STATS_EN defined:
  - event_count_o increments on every accepted event.
  - drop_count_o increments on every overrun.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Defaults. load_i at L with valid_i=1, x1=10'd32: x1_word_o = 8'hFF at L+6, 8'h00 in every other cycle; done_o at L+100.
- x2=10'd37: x2_word_o = 8'hE0 at L+6 and 8'h1F at L+7 (pulse split across two words).
- load_i with valid_i=0: all words stay 0, busy_o stays 0, done_o never pulses, event_count_o unchanged.
- Second load_i at L+51 → overrun_o at L+52 and original pulses unchanged. Third load_i at L+100 → accepted, busy_o held high, new frame words from L+102.
- y1=10'd797: y1_word_o = 8'hE0 at L+101, no pulse bits in the following frame (truncation).
- reset asserted at L+12 → all outputs 0 immediately. After release, load_i with y2=10'd40 → y2_word_o = 8'hFF at the expected cycle. With PULSE_PATTERN_STATS_EN, event_count_o reads 1.
